// File: rtl/pulse_wave_osc.sv
// pulse_wave_osc: pulse-wave DDS oscillator with duty control and glitch-free parameter updates.
// Optional hard sync input enabled by defining PULSE_WAVE_OSC_HARD_SYNC_EN.
module pulse_wave_osc #(
    parameter int OUT_WIDTH           = 12,
    parameter int PHASE_WIDTH         = 24,
    parameter int DUTY_WIDTH          = 8,
    parameter int USE_UNSIGNED_TABLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sampleEn,
    input  logic                   runEn,
    input  logic [PHASE_WIDTH-1:0] phaseInc,
    input  logic [DUTY_WIDTH-1:0]  dutyCycle,
    input  logic                   paramValid,
`ifdef PULSE_WAVE_OSC_HARD_SYNC_EN
    input  logic                   syncIn,
`endif
    output logic                   paramReady,
    output logic [OUT_WIDTH-1:0]   wave,
    output logic                   waveValid,
    output logic                   wrapPulse
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;
    localparam logic [OUT_WIDTH-1:0] HI_S  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] LO_S  = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [OUT_WIDTH-1:0] MID_U = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] HI    = USE_UNSIGNED_TABLES != 0 ? {OUT_WIDTH{1'b1}} : HI_S;
    localparam logic [OUT_WIDTH-1:0] LO    = USE_UNSIGNED_TABLES != 0 ? {OUT_WIDTH{1'b0}} : LO_S;
    localparam logic [OUT_WIDTH-1:0] MID   = USE_UNSIGNED_TABLES != 0 ? MID_U : {OUT_WIDTH{1'b0}};

    logic [1:0]             state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] inc_q, inc_d, sh_inc_q, sh_inc_d;
    logic [DUTY_WIDTH-1:0]  duty_q, duty_d, sh_duty_q, sh_duty_d;
    logic [OUT_WIDTH-1:0]   wave_q, wave_d;
    logic                   valid_q, valid_d, wrap_q, wrap_d;
    logic [PHASE_WIDTH-1:0] sum;
    logic                   carry, high, sync;

`ifdef PULSE_WAVE_OSC_HARD_SYNC_EN
    assign sync = syncIn;
`else
    assign sync = 1'b0;
`endif

    assign {carry, sum} = {1'b0, phase_q} + {1'b0, inc_q};
    assign high         = phase_q[PHASE_WIDTH-1 -: DUTY_WIDTH] < duty_q;
    assign paramReady   = state_q != PENDING;
    assign wave         = wave_q;
    assign waveValid    = valid_q;
    assign wrapPulse    = wrap_q;

    // Next-state: gating, parameter handshakes, accumulation and shadow promotion at wrap.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        duty_d    = duty_q;
        sh_inc_d  = sh_inc_q;
        sh_duty_d = sh_duty_q;
        wave_d    = wave_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        if (!runEn) begin
            state_d   = IDLE;
            wave_d    = MID;
            sh_inc_d  = '0;
            sh_duty_d = '0;
        end else if (state_q == IDLE) begin
            wave_d = MID;
            if (paramValid) begin
                inc_d   = phaseInc;
                duty_d  = dutyCycle;
                phase_d = '0;
                state_d = RUN;
            end
        end else if (state_q == RUN || state_q == PENDING) begin
            if (state_q == RUN && paramValid) begin
                sh_inc_d  = phaseInc;
                sh_duty_d = dutyCycle;
                state_d   = PENDING;
            end
            if (sampleEn) begin
                wave_d  = high ? HI : LO;
                valid_d = 1'b1;
                phase_d = sync ? '0 : sum;
                wrap_d  = carry | sync;
                if (state_q == PENDING && (carry || sync)) begin
                    inc_d   = sh_inc_q;
                    duty_d  = sh_duty_q;
                    state_d = RUN;
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            inc_q     <= '0;
            duty_q    <= '0;
            sh_inc_q  <= '0;
            sh_duty_q <= '0;
            wave_q    <= MID;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            duty_q    <= duty_d;
            sh_inc_q  <= sh_inc_d;
            sh_duty_q <= sh_duty_d;
            wave_q    <= wave_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end
endmodule

// File: doc/pulse_wave_osc.md
PULSE_WAVE_OSC -- requirements
Module: pulse_wave_osc

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 12, output sample width in bits (range 4..24).
REQ-002 SHALL have parameter PHASE_WIDTH, default 24, phase accumulator width in bits (range 8..32).
REQ-003 SHALL have parameter DUTY_WIDTH, default 8, duty-cycle word width in bits (range 1..PHASE_WIDTH).
REQ-004 SHALL have parameter USE_UNSIGNED_TABLES, default 0: 0 = signed two's-complement levels, 1 = unsigned levels.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port sampleEn, input, 1 bit, sample-rate strobe; the accumulator advances only when it is high.
REQ-008 SHALL have port runEn, input, 1 bit, oscillator gate; low forces IDLE.
REQ-009 SHALL have port phaseInc, input, PHASE_WIDTH bits, unsigned frequency word; sampled on a parameter handshake.
REQ-010 SHALL have port dutyCycle, input, DUTY_WIDTH bits, unsigned high-time fraction; sampled on a parameter handshake.
REQ-011 SHALL have port paramValid, input, 1 bit, asserts that a new phaseInc/dutyCycle pair is offered.
REQ-012 SHALL have port paramReady, output, 1 bit, asserts that the block can accept a parameter pair.
REQ-013 SHALL have port wave, output, OUT_WIDTH bits, registered output sample.
REQ-014 SHALL have port waveValid, output, 1 bit, one-cycle pulse marking a new sample on wave.
REQ-015 SHALL have port wrapPulse, output, 1 bit, one-cycle pulse when the accumulator carries out.

Function
REQ-016 SHALL implement the states IDLE, RUN and PENDING.
REQ-017 In IDLE, paramReady SHALL be 1; a handshake (paramValid and paramReady) SHALL load the active inc/duty registers, clear the phase to 0 and move to RUN, provided runEn=1.
REQ-018 In RUN, paramReady SHALL be 1; a handshake SHALL load the shadow registers and move to PENDING.
REQ-019 In PENDING, paramReady SHALL be 0; on the first sampleEn cycle whose phase update carries out, the shadow registers SHALL become active (from the next sample onward) and the state SHALL return to RUN, giving glitch-free duty and frequency changes.
REQ-020 In RUN or PENDING, on sampleEn: phase <= (phase + activeInc) mod 2^PHASE_WIDTH, and wrapPulse=1 on the next cycle if the addition carried out.
REQ-021 Level select: the output SHALL be high when phase[PHASE_WIDTH-1 -: DUTY_WIDTH] < activeDuty, evaluated on the pre-update phase; otherwise low.
REQ-022 Duty 0 SHALL give a constant low; duty 2^(DUTY_WIDTH-1) SHALL give a 50 % wave equivalent to the top-bit square.
REQ-023 Signed levels SHALL be high = +(2^(OUT_WIDTH-1)-1) and low = -(2^(OUT_WIDTH-1)-1) (12 bit: 0x7FF / 0x801); unsigned levels SHALL be high = all ones and low = 0.
REQ-024 wave and waveValid SHALL update exactly one cycle after a sampleEn cycle in RUN or PENDING; waveValid SHALL be 0 in all other cycles.
REQ-025 In IDLE, wave SHALL hold the midpoint: 0 signed, 2^(OUT_WIDTH-1) unsigned.
REQ-026 runEn=0 in any state SHALL move to IDLE on the next edge, discarding the shadow registers and any pending update; wave SHALL go to the midpoint.
REQ-027 A handshake coinciding with a carry-out in PENDING is impossible (paramReady=0); a handshake in RUN coinciding with a carry-out SHALL be applied at the following carry-out, not the current one.

Reset
REQ-028 While rst_n=0 at a clk edge: state=IDLE, phase=0, active and shadow registers=0, wave=midpoint, waveValid=0, wrapPulse=0, paramReady=1.
REQ-029 Reset mid-operation SHALL abandon any pending update with no further waveValid pulse.

Configuration
REQ-030 With macro PULSE_WAVE_OSC_HARD_SYNC_EN defined, input port syncIn (1 bit) SHALL exist; syncIn=1 on a sampleEn cycle in RUN or PENDING SHALL force the next phase to 0, assert wrapPulse, and apply any pending shadow values.
REQ-031 Without the macro, port syncIn SHALL be absent and the phase SHALL be affected only by the accumulator, handshakes and reset.

Verification
REQ-032 Defaults, signed, inc=2^22, duty=128, sampleEn always high -> wave 0x7FF for 2 samples, 0x801 for 2 samples, repeating; wrapPulse every 4 samples.
REQ-033 USE_UNSIGNED_TABLES=1, duty=64, inc=2^20 -> 0xFFF for 4 samples, then 0x000 for 12 samples per period.
REQ-034 In RUN, handshake with duty=0 mid-period -> paramReady=0 until the next wrapPulse, then constant 0x801 and paramReady back to 1.
REQ-035 runEn dropped mid-period -> next cycle wave=0x000, waveValid=0, state IDLE; a new handshake restarts from phase 0.
REQ-036 rst_n low for 1 cycle during PENDING -> all outputs at reset values and shadow values never applied.
REQ-037 With PULSE_WAVE_OSC_HARD_SYNC_EN defined, syncIn pulsed at phase 0x600000 -> next sample phase 0, wrapPulse=1, wave=0x7FF.
